// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising serial PRBS checker for an N-bit Fibonacci LFSR stream.
// Optional auto-relock after LOSS_COUNT consecutive misses: define PRBS_CHK_AUTORELOCK_EN.
module prbs_checker #(
  parameter int N          = 3,
  parameter int T          = 2,
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  // state    | meaning
  // S_FILL   | loading the first N bits of history from din
  // S_HUNT   | predicting from din-seeded history, counting consecutive hits
  // S_LOCKED | flywheel prediction, counting mismatches

  if (T < 1 || T >= N) begin : g_bad_t
    $error("prbs_checker: T must lie in 1..N-1");
  end
  if (LOCK_COUNT < 1 || LOSS_COUNT < 1) begin : g_bad_counts
    $error("prbs_checker: LOCK_COUNT and LOSS_COUNT must be at least 1");
  end

  localparam int FW = $clog2(N + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [FW-1:0] FILL_LAST  = FW'(N - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_HUNT   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:N]       h_q, h_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic             err_pulse_d;
  logic [ERR_W-1:0] err_count_d;

`ifdef PRBS_CHK_AUTORELOCK_EN
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [LW-1:0] MISS_LAST = LW'(LOSS_COUNT - 1);
  logic [LW-1:0] miss_q, miss_d;
`endif

  logic pred, bit_bad, h_zero, locked_miss;

  assign pred        = h_q[N] ^ h_q[T];
  assign bit_bad     = (din != pred);
  assign h_zero      = (h_q == '0);
  assign locked_miss = din_valid && (state_q == S_LOCKED) && bit_bad;
  assign locked      = (state_q == S_LOCKED);

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    fill_d      = fill_q;
    match_d     = match_q;
    err_pulse_d = 1'b0;
`ifdef PRBS_CHK_AUTORELOCK_EN
    miss_d      = miss_q;
`endif
    if (din_valid) begin
      unique case (state_q)
        S_FILL: begin
          h_d = {din, h_q[1:N-1]};
          if (fill_q == FILL_LAST) begin
            state_d = S_HUNT;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        S_HUNT: begin
          h_d = {din, h_q[1:N-1]};
          // an all-zero history predicts 0 forever, so it must never count as a hit
          if (!bit_bad && !h_zero) begin
            if (match_q == MATCH_LAST) begin
              state_d = S_LOCKED;
              match_d = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        S_LOCKED: begin
          // flywheel: history follows the prediction so one flipped bit costs one error
          h_d         = {pred, h_q[1:N-1]};
          err_pulse_d = bit_bad;
`ifdef PRBS_CHK_AUTORELOCK_EN
          if (bit_bad) begin
            if (miss_q == MISS_LAST) begin
              state_d = S_FILL;
              fill_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
`endif
        end
        default: state_d = S_FILL;
      endcase
    end

    // a clear colliding with a mismatch keeps that mismatch
    if (err_clr) begin
      err_count_d = locked_miss ? ERR_W'(1) : '0;
    end else if (locked_miss && (err_count != '1)) begin
      err_count_d = err_count + 1'b1;
    end else begin
      err_count_d = err_count;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FILL;
      h_q       <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
`ifdef PRBS_CHK_AUTORELOCK_EN
      miss_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      err_pulse <= err_pulse_d;
      err_count <= err_count_d;
`ifdef PRBS_CHK_AUTORELOCK_EN
      miss_q    <= miss_d;
`endif
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker (N=3, T=2, stream 1001011 repeated).
// Expected outputs are queued per driven cycle and popped after the sampling edge.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic        din_valid;
  logic        err_clr;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;

  int n_cmp = 0;
  int n_err = 0;
  int si    = 0;

  typedef struct {
    logic        l;
    logic        p;
    logic [15:0] c;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [6:0] pat = 7'b1001011;

  always #5 clk = ~clk;

  prbs_checker #(
    .N(3), .T(2), .LOCK_COUNT(8), .LOSS_COUNT(4), .ERR_W(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .err_clr   (err_clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic stream_bit(input int i);
    return pat[6 - (i % 7)];
  endfunction

  task automatic step(input logic v, input logic b, input logic clr,
                      input logic el, input logic ep, input logic [15:0] ec);
    exp_t x;
    x.l = el; x.p = ep; x.c = ec;
    din_valid = v;
    din       = b;
    err_clr   = clr;
    sb.push_back(x);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    din_valid = 1'b0;
    din       = 1'b0;
    err_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    si    = 0;
  endtask

  task automatic test_reset();
    exp_t x;
    reset = 1'b1; din_valid = 1'b1; din = 1'b1; err_clr = 1'b0;
    x.l = 1'b0; x.p = 1'b0; x.c = 16'd0;
    sb.push_back(x);
    repeat (3) @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if ({locked, err_pulse, err_count} !== {e.l, e.p, e.c}) begin
      n_err++;
      $display("FAIL reset: got l=%b p=%b c=%0d want l=%b p=%b c=%0d",
               locked, err_pulse, err_count, e.l, e.p, e.c);
    end
    din_valid = 1'b0;
    reset = 1'b0;
    si = 0;
  endtask

  task automatic test_lock();
    do_reset();
    for (int k = 1; k <= 111; k++) begin
      step(1'b1, stream_bit(si), 1'b0, (k >= 11), 1'b0, 16'd0);
      si++;
      e = sb.pop_front();
      n_cmp++;
      if ({locked, err_pulse, err_count} !== {e.l, e.p, e.c}) begin
        n_err++;
        $display("FAIL lock bit=%0d: got l=%b p=%b c=%0d want l=%b p=%b c=%0d",
                 k, locked, err_pulse, err_count, e.l, e.p, e.c);
      end
    end
  endtask

  task automatic test_single_error();
    for (int k = 0; k < 30; k++) begin
      logic bad;
      bad = (k == 5);
      step(1'b1, stream_bit(si) ^ bad, 1'b0, 1'b1, bad, (k >= 5) ? 16'd1 : 16'd0);
      si++;
      e = sb.pop_front();
      n_cmp++;
      if ({locked, err_pulse, err_count} !== {e.l, e.p, e.c}) begin
        n_err++;
        $display("FAIL single_error k=%0d: got l=%b p=%b c=%0d want l=%b p=%b c=%0d",
                 k, locked, err_pulse, err_count, e.l, e.p, e.c);
      end
    end
  endtask

  task automatic test_clear_collision();
    int exp_c;
    exp_c = 1;
    for (int k = 0; k < 22; k++) begin
      logic bad;
      bad = ((k % 5) == 3) && (k < 20);
      if (bad) exp_c++;
      step(1'b1, stream_bit(si) ^ bad, 1'b0, 1'b1, bad, 16'(exp_c));
      si++;
      e = sb.pop_front();
      n_cmp++;
      if ({locked, err_pulse, err_count} !== {e.l, e.p, e.c}) begin
        n_err++;
        $display("FAIL clr_prep k=%0d: got l=%b p=%b c=%0d want l=%b p=%b c=%0d",
                 k, locked, err_pulse, err_count, e.l, e.p, e.c);
      end
    end
    // clear together with a bad bit, then clear alone, then clean bits
    for (int k = 0; k < 6; k++) begin
      logic bad, clr;
      bad = (k == 0);
      clr = (k <= 1);
      step(1'b1, stream_bit(si) ^ bad, clr, 1'b1, bad, (k == 0) ? 16'd1 : 16'd0);
      si++;
      e = sb.pop_front();
      n_cmp++;
      if ({locked, err_pulse, err_count} !== {e.l, e.p, e.c}) begin
        n_err++;
        $display("FAIL clear_collision k=%0d: got l=%b p=%b c=%0d want l=%b p=%b c=%0d",
                 k, locked, err_pulse, err_count, e.l, e.p, e.c);
      end
    end
  endtask

  task automatic test_autorelock();
    for (int k = 0; k < 30; k++) begin
      logic bad, el, ep;
      logic [15:0] ec;
      bad = (k < 4);
      ep  = bad;
      ec  = (k < 4) ? 16'(k + 1) : 16'd4;
`ifdef PRBS_CHK_AUTORELOCK_EN
      el  = (k < 3) || (k >= 14);
`else
      el  = 1'b1;
`endif
      step(1'b1, stream_bit(si) ^ bad, 1'b0, el, ep, ec);
      si++;
      e = sb.pop_front();
      n_cmp++;
      if ({locked, err_pulse, err_count} !== {e.l, e.p, e.c}) begin
        n_err++;
        $display("FAIL autorelock k=%0d: got l=%b p=%b c=%0d want l=%b p=%b c=%0d",
                 k, locked, err_pulse, err_count, e.l, e.p, e.c);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t x;
    x.l = 1'b0; x.p = 1'b0; x.c = 16'd0;
    #3;
    reset = 1'b1;
    sb.push_back(x);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if ({locked, err_pulse, err_count} !== {e.l, e.p, e.c}) begin
      n_err++;
      $display("FAIL mid_reset: got l=%b p=%b c=%0d want l=%b p=%b c=%0d",
               locked, err_pulse, err_count, e.l, e.p, e.c);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    si = 0;
  endtask

  task automatic test_stuck0();
    do_reset();
    for (int k = 0; k < 50; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      e = sb.pop_front();
      n_cmp++;
      if ({locked, err_pulse, err_count} !== {e.l, e.p, e.c}) begin
        n_err++;
        $display("FAIL stuck0 k=%0d: got l=%b p=%b c=%0d want l=%b p=%b c=%0d",
                 k, locked, err_pulse, err_count, e.l, e.p, e.c);
      end
    end
  endtask

  task automatic test_valid_gaps();
    int vk;
    int cyc;
    vk  = 0;
    cyc = 0;
    do_reset();
    while (vk < 25) begin
      logic v, b;
      v = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (v) begin
        b = stream_bit(si);
        si++;
        vk++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      step(v, b, 1'b0, (vk >= 11), 1'b0, 16'd0);
      e = sb.pop_front();
      n_cmp++;
      if ({locked, err_pulse, err_count} !== {e.l, e.p, e.c}) begin
        n_err++;
        $display("FAIL valid_gaps cyc=%0d: got l=%b p=%b c=%0d want l=%b p=%b c=%0d",
                 cyc, locked, err_pulse, err_count, e.l, e.p, e.c);
      end
      cyc++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    err_clr   = 1'b0;
    #1;
    test_reset();
    test_lock();
    test_single_error();
    test_clear_collision();
    test_autorelock();
    test_mid_reset();
    test_stuck0();
    test_valid_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
